// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arb_state_t;
  localparam int LAT_MAX = 3;
  localparam int PERF_W = 32;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline IF/DM request ports, stalls, perf counters and memory-side bus
interface mem_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic                           if_req;
  logic [AW-1:0]                  if_addr;
  logic                           if_gnt;
  logic                           if_valid;
  logic [DW-1:0]                  if_rdata;
  logic                           dm_req;
  logic                           dm_we;
  logic [AW-1:0]                  dm_addr;
  logic [DW-1:0]                  dm_wdata;
  logic                           dm_gnt;
  logic                           dm_valid;
  logic [DW-1:0]                  dm_rdata;
  logic                           mem_en;
  logic                           mem_we;
  logic [AW-1:0]                  mem_addr;
  logic [DW-1:0]                  mem_wdata;
  logic [DW-1:0]                  mem_rdata;
  logic                           stall_if;
  logic                           stall_mem;
  logic [mem_arb_pkg::PERF_W-1:0] perf_if_wait;
  logic [mem_arb_pkg::PERF_W-1:0] perf_dm_wait;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, perf_if_wait, perf_dm_wait
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, perf_if_wait, perf_dm_wait
  );
endinterface

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: two saturating wait-cycle counters, cleared only by reset
module mem_arb_perf import mem_arb_pkg::*; (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_wait_i,
  input  logic              dm_wait_i,
  output logic [PERF_W-1:0] perf_if_wait_o,
  output logic [PERF_W-1:0] perf_dm_wait_o
);
  logic [PERF_W-1:0] if_q, if_d, dm_q, dm_d;
  // step on each waiting cycle, stick at all ones
  always_comb begin
    if_d = (if_wait_i && !(&if_q)) ? if_q + PERF_W'(1) : if_q;
    dm_d = (dm_wait_i && !(&dm_q)) ? dm_q + PERF_W'(1) : dm_q;
  end
  // counter registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      if_q <= '0;
      dm_q <= '0;
    end else begin
      if_q <= if_d;
      dm_q <= dm_d;
    end
  assign perf_if_wait_o = if_q;
  assign perf_dm_wait_o = dm_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory shared by IF and DM, DM priority with IF anti-starvation; ARB_PERF_CNT_EN adds wait counters
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int AW = 7,
  parameter int DW = 32,
  parameter int LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: LAT=%0d outside 1..%0d", LAT, LAT_MAX);
  end
  arb_state_t    state_q, state_d;
  logic [1:0]    lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          dm_we_q, dm_we_d;
  logic          if_win, dm_win, done;
  // arbitration in IDLE, latency countdown in BUSY, return path and stalls; reset forces every output low
  always_comb begin
    if_win = reset_n && state_q == IDLE && bus.if_req && (!bus.dm_req || starve_q == STARVE_TOP);
    dm_win = reset_n && state_q == IDLE && bus.dm_req && !if_win;
    done = state_q != IDLE && lat_q == 2'd1;
    state_d = if_win ? BUSY_IF : dm_win ? BUSY_DM : done ? IDLE : state_q;
    lat_d = (if_win || dm_win) ? 2'(LAT) : state_q != IDLE ? lat_q - 2'd1 : lat_q;
    starve_d = (!bus.if_req || if_win) ? '0 : (dm_win && starve_q != STARVE_TOP) ? starve_q + SW'(1) : starve_q;
    dm_we_d = dm_win ? bus.dm_we : dm_we_q;
    bus.if_valid = done && state_q == BUSY_IF;
    bus.dm_valid = done && state_q == BUSY_DM;
    if_rdata_d = bus.if_valid ? bus.mem_rdata : if_rdata_q;
    dm_rdata_d = bus.dm_valid ? (dm_we_q ? '0 : bus.mem_rdata) : dm_rdata_q;
    bus.if_rdata = if_rdata_d;
    bus.dm_rdata = dm_rdata_d;
    bus.if_gnt = if_win;
    bus.dm_gnt = dm_win;
    bus.mem_en = if_win || dm_win;
    bus.mem_we = dm_win && bus.dm_we;
    bus.mem_addr = dm_win ? bus.dm_addr : if_win ? bus.if_addr : AW'(0);
    bus.mem_wdata = (dm_win && bus.dm_we) ? bus.dm_wdata : '0;
    bus.stall_if = reset_n && bus.if_req && !bus.if_valid;
    bus.stall_mem = reset_n && bus.dm_req && !bus.dm_valid;
  end
  // state, latency counter, starvation counter and held read data; reset drops any access in flight
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q <= '0;
      starve_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      dm_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      starve_q <= starve_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      dm_we_q <= dm_we_d;
    end
`ifdef ARB_PERF_CNT_EN
  mem_arb_perf u_perf (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_wait_i      (bus.if_req && !if_win && state_q != BUSY_IF),
    .dm_wait_i      (bus.dm_req && !dm_win && state_q != BUSY_DM),
    .perf_if_wait_o (bus.perf_if_wait),
    .perf_dm_wait_o (bus.perf_dm_wait)
  );
`else
  assign bus.perf_if_wait = '0;
  assign bus.perf_dm_wait = '0;
`endif
  // a pending request keeps its address and write fields steady until granted
  assert property (@(posedge clk) disable iff (!reset_n)
    (bus.if_req && !bus.if_gnt) ##1 bus.if_req |-> $stable(bus.if_addr));
  assert property (@(posedge clk) disable iff (!reset_n)
    (bus.dm_req && !bus.dm_gnt) ##1 bus.dm_req |-> $stable({bus.dm_we, bus.dm_addr, bus.dm_wdata}));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter (LAT=1 instance plus LAT=3 instance for reset/latency)
module tb_mem_arbiter;
  localparam int L1 = 1;
  localparam int L3 = 3;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(7), .DW(32)) bus1 ();
  mem_arbiter_if #(.AW(7), .DW(32)) bus3 ();
  mem_arbiter #(.AW(7), .DW(32), .LAT(L1), .STARVE_MAX(SM)) dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1.slave));
  mem_arbiter #(.AW(7), .DW(32), .LAT(L3), .STARVE_MAX(SM)) dut3 (.clk(clk), .reset_n(rst3_n), .bus(bus3.slave));

  function automatic logic [31:0] init_pat(input logic [6:0] a);
    return a == 7'd5 ? 32'h8C22_0010 : 32'h1357_0000 ^ {25'd0, a} ^ ({25'd0, a} << 20);
  endfunction

  // memory device for the LAT=1 instance: written contents overlay the initial pattern
  bit [31:0] wmem [128];
  bit        wr [128];
  logic [31:0] rd1_q = '0, rd3_q = '0;
  always @(posedge clk) begin
    if (bus1.mem_en) begin
      if (bus1.mem_we) begin
        wmem[bus1.mem_addr] <= bus1.mem_wdata;
        wr[bus1.mem_addr] <= 1'b1;
      end
      rd1_q <= wr[bus1.mem_addr] ? wmem[bus1.mem_addr] : init_pat(bus1.mem_addr);
    end
    if (bus3.mem_en) rd3_q <= init_pat(bus3.mem_addr);
  end
  assign bus1.mem_rdata = rd1_q;
  assign bus3.mem_rdata = rd3_q;

  // reference model state: memory contents as seen in grant order
  logic [31:0] shadow [128];

  task automatic test_reset();
    bus1.if_req = 1'b1; bus1.dm_req = 1'b1; bus1.if_addr = 7'd1; bus1.dm_addr = 7'd2;
    bus1.dm_we = 1'b1; bus1.dm_wdata = 32'h1234_5678;
    @(negedge clk);
    n_chk++; if (bus1.if_gnt !== 1'b0 || bus1.dm_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", bus1.if_gnt, bus1.dm_gnt); end
    n_chk++; if (bus1.mem_en !== 1'b0 || bus1.mem_we !== 1'b0 || bus1.mem_addr !== 7'd0 || bus1.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem: got en=%b we=%b addr=%0h wd=%h expected all 0", bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata); end
    n_chk++; if (bus1.stall_if !== 1'b0 || bus1.stall_mem !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b%b expected 00", bus1.stall_if, bus1.stall_mem); end
    n_chk++; if (bus1.if_valid !== 1'b0 || bus1.dm_valid !== 1'b0 || bus1.if_rdata !== 32'd0 || bus1.dm_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_ret: got v=%b%b ird=%h drd=%h expected 0", bus1.if_valid, bus1.dm_valid, bus1.if_rdata, bus1.dm_rdata); end
    n_chk++; if (bus1.perf_if_wait !== 32'd0 || bus1.perf_dm_wait !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d %0d expected 0 0", bus1.perf_if_wait, bus1.perf_dm_wait); end
    bus1.if_req = 1'b0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus1.mem_en !== 1'b0 || bus1.stall_if !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got en=%b stall=%b expected 0 0", bus1.mem_en, bus1.stall_if); end
  endtask

  // one transaction on each requested port, both raised together; DM wins a tie, IF follows LAT+1 later
  task automatic run_txn(input bit do_if, input bit do_dm, input logic [6:0] ia, input logic [6:0] da,
                         input bit we, input logic [31:0] wd);
    int g_if, g_dm;
    logic [31:0] e_if, e_dm;
    g_if = -10; g_dm = -10; e_if = '0; e_dm = '0;
    if (do_dm) begin
      g_dm = 0;
      if (we) begin shadow[da] = wd; e_dm = '0; end else e_dm = shadow[da];
    end
    if (do_if) begin
      g_if = do_dm ? L1 + 1 : 0;
      e_if = shadow[ia];
    end
    @(posedge clk); #1;
    bus1.if_req = do_if; bus1.if_addr = ia; bus1.dm_req = do_dm; bus1.dm_we = we; bus1.dm_addr = da; bus1.dm_wdata = wd;
    for (int c = 0; c < 2 * (L1 + 1) + 1; c++) begin
      @(negedge clk);
      n_chk++; if (bus1.if_gnt !== 1'(c == g_if)) begin n_fail++; $display("FAIL if_gnt c%0d: got %b expected %b", c, bus1.if_gnt, c == g_if); end
      n_chk++; if (bus1.dm_gnt !== 1'(c == g_dm)) begin n_fail++; $display("FAIL dm_gnt c%0d: got %b expected %b", c, bus1.dm_gnt, c == g_dm); end
      n_chk++; if (bus1.if_valid !== 1'(c == g_if + L1)) begin n_fail++; $display("FAIL if_valid c%0d: got %b expected %b", c, bus1.if_valid, c == g_if + L1); end
      n_chk++; if (bus1.dm_valid !== 1'(c == g_dm + L1)) begin n_fail++; $display("FAIL dm_valid c%0d: got %b expected %b", c, bus1.dm_valid, c == g_dm + L1); end
      n_chk++; if (bus1.stall_if !== 1'(do_if && c <= g_if)) begin n_fail++; $display("FAIL stall_if c%0d: got %b expected %b", c, bus1.stall_if, do_if && c <= g_if); end
      n_chk++; if (bus1.stall_mem !== 1'(do_dm && c <= g_dm)) begin n_fail++; $display("FAIL stall_mem c%0d: got %b expected %b", c, bus1.stall_mem, do_dm && c <= g_dm); end
      if (do_if && c >= g_if + L1) begin
        n_chk++; if (bus1.if_rdata !== e_if) begin n_fail++; $display("FAIL if_rdata c%0d addr %0d: got %h expected %h", c, ia, bus1.if_rdata, e_if); end
      end
      if (do_dm && c >= g_dm + L1) begin
        n_chk++; if (bus1.dm_rdata !== e_dm) begin n_fail++; $display("FAIL dm_rdata c%0d addr %0d we %b: got %h expected %h", c, da, we, bus1.dm_rdata, e_dm); end
      end
      if (c == g_dm) begin
        n_chk++; if (bus1.mem_en !== 1'b1 || bus1.mem_we !== we || bus1.mem_addr !== da || bus1.mem_wdata !== (we ? wd : 32'd0)) begin n_fail++; $display("FAIL mem_dm c%0d: got en=%b we=%b addr=%0d wd=%h expected 1 %b %0d %h", c, bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, we, da, we ? wd : 32'd0); end
      end
      if (c == g_if) begin
        n_chk++; if (bus1.mem_en !== 1'b1 || bus1.mem_we !== 1'b0 || bus1.mem_addr !== ia) begin n_fail++; $display("FAIL mem_if c%0d: got en=%b we=%b addr=%0d expected 1 0 %0d", c, bus1.mem_en, bus1.mem_we, bus1.mem_addr, ia); end
      end
      @(posedge clk); #1;
      if (c == g_if) bus1.if_req = 1'b0;
      if (c == g_dm) bus1.dm_req = 1'b0;
    end
  endtask

  task automatic test_if_fetch();
    run_txn(1'b1, 1'b0, 7'd5, 7'd0, 1'b0, 32'd0);
  endtask

  task automatic test_write_read();
    run_txn(1'b0, 1'b1, 7'd0, 7'd3, 1'b1, 32'hDEAD_BEEF);
    run_txn(1'b0, 1'b1, 7'd0, 7'd3, 1'b0, 32'd0);
    n_chk++; if (bus1.dm_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_read: got %h expected DEADBEEF", bus1.dm_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int mode;
      logic [6:0] ia, da;
      mode = int'($urandom_range(1, 3));
      ia = 7'($urandom_range(0, 127));
      da = ($urandom % 4 == 0) ? ia : 7'($urandom_range(0, 127));
      run_txn(mode[0], mode[1], ia, da, 1'($urandom % 2), $urandom);
    end
  endtask

  // both ports request without pause: DM takes each slot until IF has lost SM in a row
  task automatic test_starve();
    int streak, run;
    streak = 0; run = 0;
    @(posedge clk); #1;
    bus1.if_req = 1'b1; bus1.if_addr = 7'd20; bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 7'd10; bus1.dm_wdata = '0;
    for (int c = 0; c < 24; c++) begin
      bit opp, e_if, e_dm;
      opp = (c % (L1 + 1)) == 0;
      e_if = opp && streak == SM;
      e_dm = opp && !e_if;
      if (e_dm) streak = (streak < SM) ? streak + 1 : SM;
      if (e_if) streak = 0;
      @(negedge clk);
      n_chk++; if (bus1.if_gnt !== e_if || bus1.dm_gnt !== e_dm) begin n_fail++; $display("FAIL starve_gnt c%0d: got if=%b dm=%b expected if=%b dm=%b", c, bus1.if_gnt, bus1.dm_gnt, e_if, e_dm); end
      if (bus1.if_gnt) run = 0;
      if (bus1.dm_gnt) begin
        run++;
        n_chk++; if (run > SM) begin n_fail++; $display("FAIL starve_bound c%0d: got %0d DM grants in a row expected at most %0d", c, run, SM); end
      end
      @(posedge clk); #1;
    end
    bus1.if_req = 1'b0; bus1.dm_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_perf();
    int w_if, w_dm, streak, busy;
    logic [31:0] e_if, e_dm;
    w_if = 0; w_dm = 0; streak = 0; busy = 0;
    for (int c = 0; c < 10; c++) begin
      int win;
      win = 0;
      if ((c % (L1 + 1)) == 0) begin
        win = (streak == SM) ? 1 : 2;
        streak = (win == 1) ? 0 : (streak < SM ? streak + 1 : SM);
        busy = win;
      end
      if (win != 1 && !(win == 0 && busy == 1)) w_if++;
      if (win != 2 && !(win == 0 && busy == 2)) w_dm++;
    end
`ifdef ARB_PERF_CNT_EN
    e_if = 32'(w_if); e_dm = 32'(w_dm);
`else
    e_if = '0; e_dm = '0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus1.if_req = 1'b1; bus1.if_addr = 7'd30; bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 7'd31;
    repeat (10) @(posedge clk);
    #1;
    bus1.if_req = 1'b0; bus1.dm_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus1.perf_if_wait !== e_if) begin n_fail++; $display("FAIL perf_if_wait: got %0d expected %0d", bus1.perf_if_wait, e_if); end
    n_chk++; if (bus1.perf_dm_wait !== e_dm) begin n_fail++; $display("FAIL perf_dm_wait: got %0d expected %0d", bus1.perf_dm_wait, e_dm); end
  endtask

  // LAT=3 instance: grant-to-valid latency, then reset one cycle after a grant
  task automatic test_lat3_reset();
    @(posedge clk); #1;
    bus3.if_req = 1'b1; bus3.if_addr = 7'd9;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++; if (bus3.if_gnt !== 1'(c == 0) || bus3.if_valid !== 1'(c == L3)) begin n_fail++; $display("FAIL lat3 c%0d: got gnt=%b valid=%b expected %b %b", c, bus3.if_gnt, bus3.if_valid, c == 0, c == L3); end
      if (c == L3) begin
        n_chk++; if (bus3.if_rdata !== init_pat(7'd9)) begin n_fail++; $display("FAIL lat3_data: got %h expected %h", bus3.if_rdata, init_pat(7'd9)); end
      end
      @(posedge clk); #1;
      if (c == 0) bus3.if_req = 1'b0;
    end
    bus3.if_req = 1'b1; bus3.if_addr = 7'd12;
    @(negedge clk);
    n_chk++; if (bus3.if_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_pre_gnt: got %b expected 1", bus3.if_gnt); end
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    n_chk++; if (bus3.if_gnt !== 1'b0 || bus3.if_valid !== 1'b0 || bus3.stall_if !== 1'b0 || bus3.mem_en !== 1'b0 || bus3.if_rdata !== 32'd0 || bus3.mem_addr !== 7'd0) begin n_fail++; $display("FAIL rst_outputs: got gnt=%b valid=%b stall=%b en=%b rd=%h addr=%0d expected all 0", bus3.if_gnt, bus3.if_valid, bus3.stall_if, bus3.mem_en, bus3.if_rdata, bus3.mem_addr); end
    repeat (2) @(posedge clk);
    #1;
    bus3.if_req = 1'b0;
    rst3_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if (bus3.if_valid !== 1'b0 || bus3.mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_dropped c%0d: got valid=%b en=%b expected 0 0", c, bus3.if_valid, bus3.mem_en); end
    end
    @(posedge clk); #1;
    bus3.if_req = 1'b1; bus3.if_addr = 7'd13;
    @(negedge clk);
    n_chk++; if (bus3.if_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_idle_gnt: got %b expected 1", bus3.if_gnt); end
    @(posedge clk); #1;
    bus3.if_req = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) shadow[a] = init_pat(7'(a));
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.dm_req = 1'b0; bus3.dm_we = 1'b0; bus3.dm_addr = '0; bus3.dm_wdata = '0;
    test_reset();
    test_if_fetch();
    test_write_read();
    test_random();
    test_starve();
    test_perf();
    test_lat3_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
